// File: rtl/sc_statemachinepoint_player_repeat.sv
// Player-point control FSM with hold-to-repeat.
// Edge-started start/left/right presses drive clear, load and shift-select strobes
// for the player point register. A held direction auto-repeats after an initial
// hold delay. Left/right limits block shifts, and a saturating counter tracks the
// number of shifts issued since the last init.
module sc_statemachinepoint_player_repeat #(
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int TIMER_W       = 25,
  parameter int MOVE_W        = 8
) (
  input  logic              SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic              SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic              SC_STATEMACHINEPOINT_startButton_InLow,
  input  logic              SC_STATEMACHINEPOINT_leftButton_InLow,
  input  logic              SC_STATEMACHINEPOINT_rightButton_InLow,
  input  logic              SC_STATEMACHINEPOINT_leftLimit_InLow,
  input  logic              SC_STATEMACHINEPOINT_rightLimit_InLow,
  output logic              SC_STATEMACHINEPOINT_clear_OutLow,
  output logic              SC_STATEMACHINEPOINT_load_OutLow,
  output logic [1:0]        SC_STATEMACHINEPOINT_shiftselection_Out,
  output logic [MOVE_W-1:0] SC_STATEMACHINEPOINT_moveCount_Out,
  output logic              SC_STATEMACHINEPOINT_repeating_OutHigh
);

  typedef enum logic [3:0] {
    S_RESET_0, S_START_0, S_IDLE, S_INIT_0, S_INIT_1,
    S_LEFT_0, S_RIGHT_0, S_HOLD_WAIT, S_REPEAT_WAIT, S_RELEASE
  } state_e;

  typedef enum logic {DIR_L = 1'b0, DIR_R = 1'b1} dir_e;

  localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);

  // Short aliases; all buttons and limits are active-low.
  logic start_n, left_n, right_n, llim_n, rlim_n;
  assign start_n = SC_STATEMACHINEPOINT_startButton_InLow;
  assign left_n  = SC_STATEMACHINEPOINT_leftButton_InLow;
  assign right_n = SC_STATEMACHINEPOINT_rightButton_InLow;
  assign llim_n  = SC_STATEMACHINEPOINT_leftLimit_InLow;
  assign rlim_n  = SC_STATEMACHINEPOINT_rightLimit_InLow;

  state_e              state_q, state_d;
  dir_e                dir_q, dir_d;
  logic                first_q, first_d;   // next shift is the first of this press
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [MOVE_W-1:0]   move_q, move_d;

  // Held-direction view used by the wait states.
  logic dir_btn_n, opp_btn_n, dir_lim_n, expired;
  assign dir_btn_n = (dir_q == DIR_L) ? left_n  : right_n;
  assign opp_btn_n = (dir_q == DIR_L) ? right_n : left_n;
  assign dir_lim_n = (dir_q == DIR_L) ? llim_n  : rlim_n;
  assign expired   = (state_q == S_HOLD_WAIT) ? (timer_q == HOLD_LAST)
                                              : (timer_q == REPEAT_LAST);

  // State, direction, timer and move-counter registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      state_q <= S_RESET_0;
      dir_q   <= DIR_L;
      first_q <= 1'b0;
      timer_q <= '0;
      move_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      first_q <= first_d;
      timer_q <= timer_d;
      move_q  <= move_d;
    end
  end

  // Next-state, timer and counter logic.
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    first_d = first_q;
    timer_d = '0;
    move_d  = move_q;
    case (state_q)
      S_RESET_0: state_d = S_START_0;
      S_START_0: state_d = S_IDLE;
      S_IDLE: begin
        if (!start_n) begin
          state_d = S_INIT_0;
        end else if (!left_n && right_n) begin
          state_d = llim_n ? S_LEFT_0 : S_RELEASE;
          dir_d   = DIR_L;
          first_d = 1'b1;
        end else if (!right_n && left_n) begin
          state_d = rlim_n ? S_RIGHT_0 : S_RELEASE;
          dir_d   = DIR_R;
          first_d = 1'b1;
        end else if (!left_n && !right_n) begin
          state_d = S_RELEASE;
        end
      end
      S_INIT_0: begin
        move_d  = '0;
        state_d = S_INIT_1;
      end
      S_INIT_1: state_d = S_RELEASE;
      S_LEFT_0, S_RIGHT_0: begin
        if (move_q != '1) move_d = move_q + MOVE_W'(1);
        state_d = first_q ? S_HOLD_WAIT : S_REPEAT_WAIT;
      end
      S_HOLD_WAIT, S_REPEAT_WAIT: begin
        if (!start_n) begin
          state_d = S_INIT_0;
        end else if (dir_btn_n || !opp_btn_n) begin
          state_d = S_RELEASE;
        end else if (expired) begin
          first_d = 1'b0;
          if (!dir_lim_n)            state_d = S_RELEASE;
          else if (dir_q == DIR_L)   state_d = S_LEFT_0;
          else                       state_d = S_RIGHT_0;
        end
        // The timer only runs while staying in the same wait state; any exit clears it.
        if (state_d == state_q) timer_d = timer_q + TIMER_W'(1);
      end
      S_RELEASE: if (start_n && left_n && right_n) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore output decode from the current state only.
  always_comb begin
    SC_STATEMACHINEPOINT_clear_OutLow       = 1'b1;
    SC_STATEMACHINEPOINT_load_OutLow        = 1'b1;
    SC_STATEMACHINEPOINT_shiftselection_Out = 2'b11;
    SC_STATEMACHINEPOINT_repeating_OutHigh  = 1'b0;
    case (state_q)
      S_INIT_0:      SC_STATEMACHINEPOINT_clear_OutLow           = 1'b0;
      S_INIT_1:      SC_STATEMACHINEPOINT_load_OutLow            = 1'b0;
      S_LEFT_0:      SC_STATEMACHINEPOINT_shiftselection_Out     = 2'b01;
      S_RIGHT_0:     SC_STATEMACHINEPOINT_shiftselection_Out     = 2'b10;
      S_REPEAT_WAIT: SC_STATEMACHINEPOINT_repeating_OutHigh      = 1'b1;
      default:       ;
    endcase
  end

  assign SC_STATEMACHINEPOINT_moveCount_Out = move_q;

endmodule

// File: tb/tb_sc_statemachinepoint_player_repeat.sv
// Self-checking bench for sc_statemachinepoint_player_repeat.
// Table-driven single-cycle vectors plus hand-written hold/limit/reset sequences.
// Expected outputs are queued when inputs are driven and compared 1 ns after the edge.
module tb_sc_statemachinepoint_player_repeat;

  localparam int H   = 8;
  localparam int R   = 4;
  localparam int MW  = 3;
  localparam int MAXC = (1 << MW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_n, lf_n, rt_n, ll_n, rl_n;
  logic          clr_n, ld_n, rep;
  logic [1:0]    sh;
  logic [MW-1:0] cnt;

  always #5 clk = ~clk;

  sc_statemachinepoint_player_repeat #(
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .TIMER_W(4), .MOVE_W(MW)
  ) dut (
    .SC_STATEMACHINEPOINT_CLOCK_50          (clk),
    .SC_STATEMACHINEPOINT_RESET_InHigh      (rst),
    .SC_STATEMACHINEPOINT_startButton_InLow (st_n),
    .SC_STATEMACHINEPOINT_leftButton_InLow  (lf_n),
    .SC_STATEMACHINEPOINT_rightButton_InLow (rt_n),
    .SC_STATEMACHINEPOINT_leftLimit_InLow   (ll_n),
    .SC_STATEMACHINEPOINT_rightLimit_InLow  (rl_n),
    .SC_STATEMACHINEPOINT_clear_OutLow      (clr_n),
    .SC_STATEMACHINEPOINT_load_OutLow       (ld_n),
    .SC_STATEMACHINEPOINT_shiftselection_Out(sh),
    .SC_STATEMACHINEPOINT_moveCount_Out     (cnt),
    .SC_STATEMACHINEPOINT_repeating_OutHigh (rep)
  );

  typedef struct packed {
    logic          clr;
    logic          ld;
    logic [1:0]    sh;
    logic [MW-1:0] cnt;
    logic          rep;
  } out_t;

  typedef struct {
    logic st, lf, rt, ll, rl;
    out_t exp;
  } vec_t;

  out_t  exp_q[$];
  string name_q[$];
  vec_t  tbl[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  function automatic out_t o(input logic c, input logic l, input logic [1:0] s,
                             input int k, input logic r);
    out_t v;
    v.clr = c; v.ld = l; v.sh = s; v.cnt = MW'(k); v.rep = r;
    return v;
  endfunction

  function automatic out_t dflt(input int k);
    return o(1'b1, 1'b1, 2'b11, k, 1'b0);
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic compare(input string nm, input out_t e);
    out_t a;
    a = {clr_n, ld_n, sh, cnt, rep};
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s: got clr=%b ld=%b sh=%b cnt=%0d rep=%b, want clr=%b ld=%b sh=%b cnt=%0d rep=%b",
               nm, a.clr, a.ld, a.sh, a.cnt, a.rep, e.clr, e.ld, e.sh, e.cnt, e.rep);
    end
  endtask

  task automatic drive(input logic s, input logic l, input logic r, input logic ll, input logic rl);
    st_n = s; lf_n = l; rt_n = r; ll_n = ll; rl_n = rl;
  endtask

  // One clock; pops and compares one scoreboard entry if one was queued.
  task automatic tick();
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) compare(name_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic expect_next(input string nm, input out_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
  endtask

  function automatic void add(input logic s, input logic l, input logic r,
                              input logic ll, input logic rl, input out_t e);
    vec_t v;
    v.st = s; v.lf = l; v.rt = r; v.ll = ll; v.rl = rl; v.exp = e;
    tbl.push_back(v);
  endfunction

  // Hold one direction for n cycles from IDLE. Shift pulses land on tick 1,
  // then H+1 later, then every R+1. After pulse number drop_after the limit
  // for that direction goes low, so no further pulse may appear.
  task automatic hold_dir(input bit is_r, input int n, input int drop_after, input int c0);
    int   np, last, next_p;
    bit   dropped, is_p;
    out_t e;
    np = 0; last = 0; next_p = 1; dropped = 0;
    drive(1'b1, is_r ? 1'b1 : 1'b0, is_r ? 1'b0 : 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= n; i++) begin
      is_p = (i == next_p) && !dropped;
      e = dflt(sat(c0 + np));
      if (is_p) e.sh = is_r ? 2'b10 : 2'b01;
      e.rep = !is_p && (np >= 2) && (!dropped || i <= last + R);
      expect_next($sformatf("hold_%s_t%0d", is_r ? "right" : "left", i), e);
      if (is_p) begin
        np++;
        last   = i;
        next_p = i + ((np == 1) ? H + 1 : R + 1);
        if (np == drop_after) begin
          dropped = 1'b1;
          if (is_r) rl_n = 1'b0; else ll_n = 1'b0;
        end
      end
    end
  endtask

  // After a hold that ended exactly on a shift pulse: release everything.
  task automatic release_tail(input int c);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_next("tail_repeat_wait", o(1'b1, 1'b1, 2'b11, c, 1'b1));
    expect_next("tail_release",     dflt(c));
    expect_next("tail_idle",        dflt(c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed single-cycle table: init, taps, no-move presses, priority.
    add(1,1,1,1,1, dflt(0));                    // RESET_0 -> START_0
    add(1,1,1,1,1, dflt(0));                    // -> IDLE
    add(0,1,1,1,1, o(0,1,2'b11,0,0));           // INIT_0
    add(0,1,1,1,1, o(1,0,2'b11,0,0));           // INIT_1
    add(0,1,1,1,1, dflt(0));                    // RELEASE, start still held
    add(1,1,1,1,1, dflt(0));                    // IDLE
    add(1,0,1,1,1, o(1,1,2'b01,0,0));           // left tap: LEFT_0
    add(1,0,1,1,1, dflt(1));                    // HOLD_WAIT
    add(1,1,1,1,1, dflt(1));                    // released -> RELEASE
    add(1,1,1,1,1, dflt(1));                    // IDLE
    add(1,0,1,1,1, o(1,1,2'b01,1,0));           // second tap
    add(1,0,1,1,1, dflt(2));
    add(1,1,1,1,1, dflt(2));
    add(1,1,1,1,1, dflt(2));
    add(1,0,0,1,1, dflt(2));                    // both pressed -> RELEASE
    add(1,0,0,1,1, dflt(2));
    add(1,0,1,1,1, dflt(2));                    // still one press: no shift
    add(1,1,1,1,1, dflt(2));                    // IDLE
    add(1,0,1,0,1, dflt(2));                    // left at left limit
    add(1,0,1,0,1, dflt(2));
    add(1,1,1,0,1, dflt(2));
    add(1,1,0,1,0, dflt(2));                    // right at right limit
    add(1,1,1,1,1, dflt(2));
    add(1,1,0,1,1, o(1,1,2'b10,2,0));           // right tap
    add(1,1,1,1,1, dflt(3));                    // HOLD_WAIT regardless
    add(1,1,1,1,1, dflt(3));                    // RELEASE
    add(1,1,1,1,1, dflt(3));                    // IDLE
    add(1,0,1,1,1, o(1,1,2'b01,3,0));           // left, then opposite pressed
    add(1,0,1,1,1, dflt(4));
    add(1,0,0,1,1, dflt(4));                    // opposite -> RELEASE
    add(1,1,1,1,1, dflt(4));
    add(0,0,1,1,1, o(0,1,2'b11,4,0));           // start beats left
    add(1,1,1,1,1, o(1,0,2'b11,0,0));
    add(1,1,1,1,1, dflt(0));
    add(1,1,1,1,1, dflt(0));
    add(1,0,1,1,1, o(1,1,2'b01,0,0));           // start during HOLD_WAIT
    add(1,0,1,1,1, dflt(1));
    add(0,0,1,1,1, o(0,1,2'b11,1,0));
    add(1,1,1,1,1, o(1,0,2'b11,0,0));
    add(1,1,1,1,1, dflt(0));
    add(1,1,1,1,1, dflt(0));

    // Reset.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #3;
    compare("reset_state", dflt(0));
    tick();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].lf, tbl[i].rt, tbl[i].ll, tbl[i].rl);
      expect_next($sformatf("table_%0d", i), tbl[i].exp);
    end

    // Right held 30 cycles: pulses at 1,10,15,20,25,30 -> 6 moves.
    hold_dir(1'b1, 30, 0, 0);
    release_tail(6);

    // Re-init to zero the counter.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_next("reinit_clear", o(0,1,2'b11,6,0));
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_next("reinit_load",  o(1,0,2'b11,0,0));
    expect_next("reinit_rel",   dflt(0));
    expect_next("reinit_idle",  dflt(0));

    // Left held, left limit drops after the 2nd pulse: no 3rd pulse.
    hold_dir(1'b0, 20, 2, 0);
    ll_n = 1'b1;                                  // limit clears, left still held
    for (int i = 0; i < 3; i++) expect_next($sformatf("limit_release_%0d", i), dflt(2));
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_next("limit_to_idle", dflt(2));
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_next("after_limit_tap", o(1,1,2'b01,2,0));
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_next("after_limit_wait", dflt(3));
    expect_next("after_limit_rel",  dflt(3));
    expect_next("after_limit_idle", dflt(3));

    // Ten held moves from 3: counter saturates at MAXC.
    hold_dir(1'b1, 50, 0, 3);
    release_tail(MAXC);

    // Reset during LEFT_0.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_next("pre_rst_left0", o(1,1,2'b01,MAXC,0));
    #2 rst = 1'b1;
    #1 compare("rst_in_left0", dflt(0));
    tick();
    rst = 1'b0;                                    // left still held across reset
    expect_next("restart_reset0", dflt(0));
    expect_next("restart_start0", dflt(0));
    expect_next("restart_left0",  o(1,1,2'b01,0,0));
    expect_next("pre_rst_hold_a", dflt(1));
    expect_next("pre_rst_hold_b", dflt(1));

    // Reset during HOLD_WAIT.
    #2 rst = 1'b1;
    #1 compare("rst_in_hold", dflt(0));
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_next("post_rst_a", dflt(0));
    expect_next("post_rst_b", dflt(0));
    expect_next("post_rst_c", dflt(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
